// File: rtl/ram_mfc_responder.sv
// ram_mfc_responder: byte-addressed big-endian RAM behind the ramMFA/ramMFC handshake.
// Optional RAM_ALIGN_CHECK_EN flags misaligned halfword/word requests instead of masking.
module ram_mfc_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              resetN,
  input  logic              ramMFA,
  input  logic              ramRW,
  input  logic [1:0]        ramDataSize,
  input  logic [ADDR_W-1:0] ramAddress,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              ramMFC,
  output logic              alignErr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         DEPTH   = 2**ADDR_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [1:0]        sz_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic              idle;
  logic              a_rw;
  logic [1:0]        a_sz;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_din;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              misal;
  logic              fire;
  logic              we;
  logic [31:0]       rdata;

  // In IDLE the live inputs are used so a zero-wait access completes on the capture edge.
  always_comb begin
    idle   = (state == IDLE);
    a_rw   = idle ? ramRW       : rw_q;
    a_sz   = idle ? ramDataSize : sz_q;
    a_addr = idle ? ramAddress  : addr_q;
    a_din  = idle ? dataIn      : din_q;
  end

  always_comb begin
    a0    = a_addr;
    misal = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
    misal = ((a_sz == 2'b01) && a_addr[0]) ||
            (a_sz[1] && (a_addr[1:0] != 2'b00));
`else
    unique case (a_sz)
      2'b00:   a0 = a_addr;
      2'b01:   a0 = {a_addr[ADDR_W-1:1], 1'b0};
      default: a0 = {a_addr[ADDR_W-1:2], 2'b00};
    endcase
`endif
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
  end

  always_comb begin
    fire = ramMFA &&
           ((idle && (WAIT_LD == 4'd0)) ||
            ((state == BUSY) && (cnt == 4'd1)));
    we   = resetN && fire && a_rw && !misal;
    unique case (a_sz)
      2'b00:   rdata = {24'h0, mem[a0]};
      2'b01:   rdata = {16'h0, mem[a0], mem[a1]};
      default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (we) begin
      unique case (a_sz)
        2'b00: mem[a0] <= a_din[7:0];
        2'b01: begin
          mem[a0] <= a_din[15:8];
          mem[a1] <= a_din[7:0];
        end
        default: begin
          mem[a0] <= a_din[31:24];
          mem[a1] <= a_din[23:16];
          mem[a2] <= a_din[15:8];
          mem[a3] <= a_din[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      sz_q    <= 2'b00;
      addr_q  <= '0;
      din_q   <= 32'h0;
      dataOut <= 32'h0;
      ramMFC  <= 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
      alignErr <= 1'b0;
`endif
    end else begin
      if (fire) begin
        ramMFC <= 1'b1;
        state  <= DONE;
        if (misal)
          dataOut <= 32'h0;
        else if (!a_rw)
          dataOut <= rdata;
`ifdef RAM_ALIGN_CHECK_EN
        alignErr <= misal;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (ramMFA) begin
              rw_q   <= ramRW;
              sz_q   <= ramDataSize;
              addr_q <= ramAddress;
              din_q  <= dataIn;
              cnt    <= WAIT_LD;
              state  <= BUSY;
            end
          end
          BUSY: begin
            if (!ramMFA) begin
              cnt   <= 4'd0;
              state <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          DONE: begin
            if (!ramMFA) begin
              ramMFC <= 1'b0;
              state  <= IDLE;
`ifdef RAM_ALIGN_CHECK_EN
              alignErr <= 1'b0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef RAM_ALIGN_CHECK_EN
  assign alignErr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_mfc_responder.sv
// tb_ram_mfc_responder: directed handshake vectors with hand-computed results.
// Expectations for the misaligned read follow RAM_ALIGN_CHECK_EN.
module tb_ram_mfc_responder;

  localparam int AW = 9;
  localparam int WC = 2;

  logic          Clk;
  logic          resetN;
  logic          ramMFA;
  logic          ramRW;
  logic [1:0]    ramDataSize;
  logic [AW-1:0] ramAddress;
  logic [31:0]   dataIn;
  logic [31:0]   dataOut;
  logic          ramMFC;
  logic          alignErr;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_rd;

  ram_mfc_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk),
    .resetN(resetN),
    .ramMFA(ramMFA),
    .ramRW(ramRW),
    .ramDataSize(ramDataSize),
    .ramAddress(ramAddress),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .ramMFC(ramMFC),
    .alignErr(alignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic rw,
                      input logic [1:0] sz, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [31:0] exp_out,
                      input logic exp_err);
    @(negedge Clk);
    ramRW       = rw;
    ramDataSize = sz;
    ramAddress  = a;
    dataIn      = d;
    ramMFA      = 1'b1;
    for (int i = 1; i <= WC; i++) begin
      @(posedge Clk);
      #1;
    end
    chk({tag, "_mfc_early"}, {31'b0, ramMFC}, 32'd0);
    @(posedge Clk);
    #1;
    chk({tag, "_mfc"}, {31'b0, ramMFC}, 32'd1);
    chk({tag, "_dout"}, dataOut, exp_out);
    chk({tag, "_aerr"}, {31'b0, alignErr}, {31'b0, exp_err});
    @(negedge Clk);
    ramRW       = ~rw;
    ramAddress  = a ^ 9'h1ff;
    dataIn      = ~d;
    ramDataSize = ~sz;
    @(posedge Clk);
    #1;
    chk({tag, "_hold_mfc"}, {31'b0, ramMFC}, 32'd1);
    chk({tag, "_hold_dout"}, dataOut, exp_out);
    @(negedge Clk);
    ramMFA = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, "_rel_mfc"}, {31'b0, ramMFC}, 32'd0);
    chk({tag, "_rel_aerr"}, {31'b0, alignErr}, 32'd0);
  endtask

  initial begin
    resetN      = 1'b0;
    ramMFA      = 1'b0;
    ramRW       = 1'b0;
    ramDataSize = 2'b00;
    ramAddress  = '0;
    dataIn      = 32'h0;
    last_rd     = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_mfc", {31'b0, ramMFC}, 32'd0);
    chk("rst_dout", dataOut, 32'h0);
    chk("rst_aerr", {31'b0, alignErr}, 32'd0);
    @(negedge Clk);
    resetN = 1'b1;

    xfer("w8", 1'b1, 2'b10, 9'd8, 32'h01020304, last_rd, 1'b0);
    last_rd = 32'h01020304;
    xfer("r8", 1'b0, 2'b10, 9'd8, 32'h0, last_rd, 1'b0);

    // Reset lands mid-BUSY of an overwrite of addr 8.
    @(negedge Clk);
    ramRW       = 1'b1;
    ramDataSize = 2'b10;
    ramAddress  = 9'd8;
    dataIn      = 32'hFFFFFFFF;
    ramMFA      = 1'b1;
    @(posedge Clk);
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_mfc", {31'b0, ramMFC}, 32'd0);
    chk("arst_dout", dataOut, 32'h0);
    @(negedge Clk);
    ramMFA = 1'b0;
    @(negedge Clk);
    resetN  = 1'b1;
    last_rd = 32'h0;
    last_rd = 32'h01020304;
    xfer("r8_after_rst", 1'b0, 2'b10, 9'd8, 32'h0, last_rd, 1'b0);

    xfer("w4", 1'b1, 2'b10, 9'd4, 32'hDEADBEEF, last_rd, 1'b0);
    xfer("r4", 1'b0, 2'b10, 9'd4, 32'h0, 32'hDEADBEEF, 1'b0);
    xfer("rb5", 1'b0, 2'b00, 9'd5, 32'h0, 32'h000000AD, 1'b0);
    xfer("rh6", 1'b0, 2'b01, 9'd6, 32'h0, 32'h0000BEEF, 1'b0);
    xfer("rb7", 1'b0, 2'b00, 9'd7, 32'h0, 32'h000000EF, 1'b0);
    last_rd = 32'h000000EF;

    xfer("wb7", 1'b1, 2'b00, 9'd7, 32'hFFFFFF11, last_rd, 1'b0);
    xfer("r4_b", 1'b0, 2'b10, 9'd4, 32'h0, 32'hDEADBE11, 1'b0);
    last_rd = 32'hDEADBE11;
    xfer("wh4", 1'b1, 2'b01, 9'd4, 32'h1234CAFE, last_rd, 1'b0);
    xfer("r4_h", 1'b0, 2'b11, 9'd4, 32'h0, 32'hCAFEBE11, 1'b0);
    last_rd = 32'hCAFEBE11;

    xfer("w12", 1'b1, 2'b10, 9'd12, 32'hA5A5A5A5, last_rd, 1'b0);

    // Abort: request withdrawn one edge after capture.
    @(negedge Clk);
    ramRW       = 1'b1;
    ramDataSize = 2'b10;
    ramAddress  = 9'd12;
    dataIn      = 32'h12345678;
    ramMFA      = 1'b1;
    @(negedge Clk);
    ramMFA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      chk("abort_mfc", {31'b0, ramMFC}, 32'd0);
    end
    xfer("r12", 1'b0, 2'b10, 9'd12, 32'h0, 32'hA5A5A5A5, 1'b0);
    last_rd = 32'hA5A5A5A5;

`ifdef RAM_ALIGN_CHECK_EN
    xfer("r6_mis", 1'b0, 2'b10, 9'd6, 32'h0, 32'h0, 1'b1);
`else
    xfer("r6_mis", 1'b0, 2'b10, 9'd6, 32'h0, 32'hCAFEBE11, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ram_mfc_responder.md
# ram_mfc_responder

Byte-addressed RAM responder that serves the control unit's memory-function handshake (ramMFA/ramMFC). It captures an access request (read/write, byte/halfword/word, 9-bit byte address), waits a configurable number of cycles to model memory latency, performs the access big-endian, and then asserts ramMFC until the requester drops ramMFA. It sits between the control unit and the datapath's MAR/MDR and replaces the ideal RAM model used in fetch and load/store.

## Interface
- ADDR_W, 9, byte address width; memory depth is 2**ADDR_W bytes.
- WAIT_CYCLES, 2, extra latency cycles between request capture and access (0 allowed, max 15).

- Clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- ramMFA  in  1  memory function activate (request); level, held high until ramMFC is seen.
- ramRW  in  1  0 = read, 1 = write.
- ramDataSize  in  2  00 = byte, 01 = halfword, 10 and 11 = word.
- ramAddress  in  ADDR_W  byte address.
- dataIn  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- dataOut  out  32  read data, zero-extended, right-justified.
- ramMFC  out  1  memory function complete.
- alignErr  out  1  misaligned request flag (present only when RAM_ALIGN_CHECK_EN is defined; otherwise tied 0).

## Operation
- Storage: 2**ADDR_W bytes; contents are not cleared by reset.
- Endianness: big-endian; word at address A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}; halfword is {mem[A], mem[A+1]}.
- States: IDLE, BUSY, DONE.
- IDLE: on rising edge with ramMFA=1, latch ramRW, ramDataSize, ramAddress, dataIn; load wait counter with WAIT_CYCLES; go BUSY.
- BUSY: counter decrements each edge; at the edge where counter is 0 the access executes (write committed to memory, or dataOut loaded) and ramMFC is set; go DONE.
- BUSY abort: if ramMFA is sampled 0 in BUSY, discard request, no memory write, ramMFC stays 0, go IDLE.
- DONE: ramMFC and dataOut held stable while ramMFA=1; on edge sampling ramMFA=0, clear ramMFC, go IDLE. dataOut keeps last read value until next read completes.
- Write: only the addressed bytes change; dataOut unchanged by writes.
- Inputs other than ramMFA are ignored outside IDLE (latched copy used).
- Address wrap: word/halfword bytes beyond the top address wrap modulo 2**ADDR_W (only reachable without the align check).

## Timing
- Reset (resetN=0, any time, asynchronous): state IDLE, ramMFC=0, dataOut=0, alignErr=0, counter=0; any in-flight write is dropped.
- Latency: counting the edge that samples ramMFA=1 in IDLE as edge 1, ramMFC rises after edge WAIT_CYCLES+1 (3 edges by default; 1 edge with WAIT_CYCLES=0).
- ramMFC falls after the first edge that samples ramMFA=0 in DONE; a new request is accepted no earlier than the following edge (IDLE must be visited for ≥1 cycle).
- Four-phase handshake: requester must not raise ramMFA again until ramMFC is 0.
- Requester may update ramMFA on the falling edge; the responder samples only on rising edges.

## Configuration
- RAM_ALIGN_CHECK_EN defined: halfword with address[0]=1 or word with address[1:0]≠0 is misaligned; no memory access, dataOut loaded with 0, alignErr=1 and ramMFC=1 asserted on the normal completion edge; both cleared on handshake release.
- Undefined: alignErr tied 0; halfword address forced to address & ~1, word to address & ~3; access proceeds normally.

## Test plan
- Reset: drive resetN=0 mid-BUSY of a write to addr 8 -> ramMFC=0, dataOut=0 immediately; later word read of addr 8 returns prior contents.
- Word write 0xDEADBEEF to addr 4, then word read addr 4 -> dataOut=0xDEADBEEF, ramMFC high exactly after 3rd edge (WAIT_CYCLES=2), held until ramMFA drops.
- Sub-word reads after above: byte addr 5 -> 0x000000AD; halfword addr 6 -> 0x0000BEEF; byte addr 7 -> 0x000000EF.
- Byte write 0x11 to addr 7, then word read addr 4 -> 0xDEADBE11; halfword write 0xCAFE to addr 4 then word read -> 0xCAFEBE11.
- Abort: raise ramMFA for write of 0x12345678 to addr 12, drop it after 1 edge -> ramMFC never rises, word read addr 12 unchanged.
- Misaligned word read addr 6: with RAM_ALIGN_CHECK_EN -> alignErr=1, ramMFC=1, dataOut=0; without -> reads addr 4 (0xCAFEBE11), alignErr=0.
